// File: rtl/vga_sync_gen_pkg.sv
// Shared raster constants for vga_sync_gen and its consumers: default 640x480@60 timing,
// display_addr field layout and small compare helpers.
package vga_sync_gen_pkg;

    localparam int DEF_CLK_DIV     = 2;
    localparam int DEF_H_TOTAL     = 800;
    localparam int DEF_H_SYNC      = 96;
    localparam int DEF_H_ACT_START = 144;
    localparam int DEF_H_ACT_LEN   = 640;
    localparam int DEF_V_TOTAL     = 525;
    localparam int DEF_V_SYNC      = 2;
    localparam int DEF_V_ACT_START = 35;
    localparam int DEF_V_ACT_LEN   = 480;

    localparam int ADDR_W    = 22;
    localparam int CNT_W     = 10;
    localparam int FRAME_W   = 8;
    localparam int HSYNC_BIT = 21;
    localparam int VSYNC_BIT = 20;

    // Field order matches the f3_gpu decode: {hsync, vsync, x[9:0], y[9:0]}.
    typedef struct packed {
        logic             hsync;
        logic             vsync;
        logic [CNT_W-1:0] x;
        logic [CNT_W-1:0] y;
    } display_addr_t;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // 11-bit compares so a bound of 1024 does not wrap.
    function automatic logic below(input logic [CNT_W-1:0] pos, input int bound);
        return {1'b0, pos} < 11'(bound);
    endfunction

    function automatic logic in_window(input logic [CNT_W-1:0] pos, input int start, input int len);
        return ({1'b0, pos} >= 11'(start)) && ({1'b0, pos} < 11'(start + len));
    endfunction

endpackage

// File: rtl/vga_sync_gen_wrap_counter.sv
// Enable-gated modulo counter; wrap is combinational so the parent can chain counters
// and register outputs from count_next in the same cycle.
module wrap_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 15
) (
    input  logic             sysclk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_next,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    assign wrap = en && (count == MAX_V);

    always_comb begin
        count_next = count;
        if (wrap) begin
            count_next = '0;
        end else if (en) begin
            count_next = count + WIDTH'(1);
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel-rate divider plus h/v scan counters, producing registered
// sync, blanking, frame strobes and the packed display_addr word for f3_gpu.
module vga_sync_gen
    import vga_sync_gen_pkg::*;
#(
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter int H_TOTAL     = DEF_H_TOTAL,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_ACT_START = DEF_H_ACT_START,
    parameter int H_ACT_LEN   = DEF_H_ACT_LEN,
    parameter int V_TOTAL     = DEF_V_TOTAL,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_ACT_START = DEF_V_ACT_START,
    parameter int V_ACT_LEN   = DEF_V_ACT_LEN
) (
    input  logic               sysclk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  display_addr,
    output logic               hsync,
    output logic               vsync,
    output logic               pixel_en,
    output logic               active,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count
);

    localparam int DIV_W = cnt_width(CLK_DIV);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;
    logic             div_wrap;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] h_next;
    logic             h_wrap;
    logic [CNT_W-1:0] v_cnt;
    logic [CNT_W-1:0] v_next;
    logic             v_wrap;
    logic             cnt_unused;

    display_addr_t    addr_q;
    display_addr_t    addr_next;
    logic             active_next;

    wrap_counter #(
        .WIDTH (DIV_W),
        .MAX   (CLK_DIV - 1)
    ) u_div (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .en         (1'b1),
        .count      (div_cnt),
        .count_next (div_next),
        .wrap       (div_wrap)
    );

    wrap_counter #(
        .WIDTH (CNT_W),
        .MAX   (H_TOTAL - 1)
    ) u_h (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .en         (div_wrap),
        .count      (h_cnt),
        .count_next (h_next),
        .wrap       (h_wrap)
    );

    wrap_counter #(
        .WIDTH (CNT_W),
        .MAX   (V_TOTAL - 1)
    ) u_v (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .en         (h_wrap),
        .count      (v_cnt),
        .count_next (v_next),
        .wrap       (v_wrap)
    );

    // Outputs are built from the post-edge counter values, so the registered state is only
    // observed through the *_next nets.
    assign cnt_unused = ^{div_cnt, div_next, h_cnt, v_cnt};

    always_comb begin
        addr_next.hsync = ~below(h_next, H_SYNC);
        addr_next.vsync = ~below(v_next, V_SYNC);
        addr_next.x     = h_next;
        addr_next.y     = v_next;
        active_next     = in_window(h_next, H_ACT_START, H_ACT_LEN)
                       && in_window(v_next, V_ACT_START, V_ACT_LEN);
    end

    // v only wraps on an h wrap, so v_wrap alone marks the frame boundary.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            pixel_en    <= 1'b0;
            active      <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            addr_q      <= addr_next;
            pixel_en    <= div_wrap;
            active      <= active_next;
            frame_start <= v_wrap;
            if (v_wrap) begin
                frame_count <= frame_count + FRAME_W'(1);
            end
        end
    end

    assign display_addr = addr_q;
    assign hsync        = display_addr[HSYNC_BIT];
    assign vsync        = display_addr[VSYNC_BIT];

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench: three vga_sync_gen configurations compared every cycle against an
// arithmetic raster model driven by the number of clock edges since reset release.
module tb_vga_sync_gen;

    localparam int A_D = 2, A_HT = 800, A_HS = 96, A_HAS = 144, A_HAL = 640;
    localparam int A_VT = 525, A_VS = 2, A_VAS = 35, A_VAL = 480;
    localparam int B_D = 3, B_HT = 10, B_HS = 2, B_HAS = 3, B_HAL = 6;
    localparam int B_VT = 5, B_VS = 1, B_VAS = 1, B_VAL = 3;
    localparam int C_D = 1, C_HT = 1024, C_HS = 100, C_HAS = 1000, C_HAL = 24;
    localparam int C_VT = 3, C_VS = 1, C_VAS = 1, C_VAL = 2;

    logic sysclk = 1'b0;
    logic rst_n  = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   n = 0;

    always #5 sysclk = ~sysclk;

    // Edges seen since reset release; the raster position follows from this alone.
    always @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else        n <= n + 1;
    end

    logic [21:0] a_addr, b_addr, c_addr;
    logic        a_hs, a_vs, a_pe, a_act, a_fs;
    logic        b_hs, b_vs, b_pe, b_act, b_fs;
    logic        c_hs, c_vs, c_pe, c_act, c_fs;
    logic [7:0]  a_fc, b_fc, c_fc;
    logic [34:0] a_obs, b_obs, c_obs;

    assign a_obs = {a_addr, a_hs, a_vs, a_pe, a_act, a_fs, a_fc};
    assign b_obs = {b_addr, b_hs, b_vs, b_pe, b_act, b_fs, b_fc};
    assign c_obs = {c_addr, c_hs, c_vs, c_pe, c_act, c_fs, c_fc};

    vga_sync_gen dut_a (
        .sysclk(sysclk), .rst_n(rst_n), .display_addr(a_addr), .hsync(a_hs), .vsync(a_vs),
        .pixel_en(a_pe), .active(a_act), .frame_start(a_fs), .frame_count(a_fc)
    );

    vga_sync_gen #(
        .CLK_DIV(B_D), .H_TOTAL(B_HT), .H_SYNC(B_HS), .H_ACT_START(B_HAS), .H_ACT_LEN(B_HAL),
        .V_TOTAL(B_VT), .V_SYNC(B_VS), .V_ACT_START(B_VAS), .V_ACT_LEN(B_VAL)
    ) dut_b (
        .sysclk(sysclk), .rst_n(rst_n), .display_addr(b_addr), .hsync(b_hs), .vsync(b_vs),
        .pixel_en(b_pe), .active(b_act), .frame_start(b_fs), .frame_count(b_fc)
    );

    vga_sync_gen #(
        .CLK_DIV(C_D), .H_TOTAL(C_HT), .H_SYNC(C_HS), .H_ACT_START(C_HAS), .H_ACT_LEN(C_HAL),
        .V_TOTAL(C_VT), .V_SYNC(C_VS), .V_ACT_START(C_VAS), .V_ACT_LEN(C_VAL)
    ) dut_c (
        .sysclk(sysclk), .rst_n(rst_n), .display_addr(c_addr), .hsync(c_hs), .vsync(c_vs),
        .pixel_en(c_pe), .active(c_act), .frame_start(c_fs), .frame_count(c_fc)
    );

    // Expected {display_addr, hsync, vsync, pixel_en, active, frame_start, frame_count}
    // after t edges: pixel p = t/D, h = p mod H_TOTAL, v = (p div H_TOTAL) mod V_TOTAL.
    function automatic logic [34:0] model(input int t, input int d, input int ht, input int hs_w,
                                          input int has, input int hal, input int vt,
                                          input int vs_w, input int vas, input int val);
        int p, h, v, f;
        logic hs, vs, pe, act, fs;
        logic [9:0] h10, v10;
        logic [7:0] f8;
        if (t == 0) return '0;
        p   = t / d;
        h   = p % ht;
        v   = (p / ht) % vt;
        f   = (p / (ht * vt)) % 256;
        pe  = (t % d) == 0;
        fs  = pe && h == 0 && v == 0;
        hs  = !(h < hs_w);
        vs  = !(v < vs_w);
        act = (h >= has) && (h < has + hal) && (v >= vas) && (v < vas + val);
        h10 = 10'(h);
        v10 = 10'(v);
        f8  = 8'(f);
        return {hs, vs, h10, v10, hs, vs, pe, act, fs, f8};
    endfunction

    function automatic logic [34:0] exp_a(input int t);
        return model(t, A_D, A_HT, A_HS, A_HAS, A_HAL, A_VT, A_VS, A_VAS, A_VAL);
    endfunction
    function automatic logic [34:0] exp_b(input int t);
        return model(t, B_D, B_HT, B_HS, B_HAS, B_HAL, B_VT, B_VS, B_VAS, B_VAL);
    endfunction
    function automatic logic [34:0] exp_c(input int t);
        return model(t, C_D, C_HT, C_HS, C_HAS, C_HAL, C_VT, C_VS, C_VAS, C_VAL);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat ($urandom_range(3, 40)) @(negedge sysclk);
        checks++;
        if (a_obs !== 35'h0 || b_obs !== 35'h0 || c_obs !== 35'h0) begin
            failures++;
            $display("FAIL reset_hold got a=%h b=%h c=%h exp=0", a_obs, b_obs, c_obs);
        end
        rst_n = 1'b1;
        @(posedge sysclk);
        #1;
        checks++;
        if (a_obs !== exp_a(n) || b_obs !== exp_b(n) || c_obs !== exp_c(n)) begin
            failures++;
            $display("FAIL reset_first_edge n=%0d got a=%h b=%h c=%h exp a=%h b=%h c=%h",
                     n, a_obs, b_obs, c_obs, exp_a(n), exp_b(n), exp_c(n));
        end
    endtask

    task automatic test_default_line();
        int hs_strobes = 0;
        int wrap_n[$];
        int len = 2 * A_HT * A_D + int'($urandom_range(10, 200));
        for (int i = 0; i < len; i++) begin
            @(negedge sysclk);
            checks++;
            if (a_obs !== exp_a(n)) begin
                failures++;
                if (failures < 20) $display("FAIL line_a n=%0d got=%h exp=%h", n, a_obs, exp_a(n));
            end
            checks++;
            if (b_obs !== exp_b(n) || c_obs !== exp_c(n)) begin
                failures++;
                if (failures < 20) $display("FAIL line_bc n=%0d got b=%h c=%h exp b=%h c=%h",
                                            n, b_obs, c_obs, exp_b(n), exp_c(n));
            end
            if (a_pe && !a_hs && a_addr[9:0] == 10'd1) hs_strobes++;
            if (a_pe && a_addr[19:10] == 10'd0) wrap_n.push_back(n);
        end
        checks++;
        if (hs_strobes != A_HS) begin
            failures++;
            $display("FAIL hsync_width got=%0d exp=%0d", hs_strobes, A_HS);
        end
        checks++;
        if (wrap_n.size() < 2 || wrap_n[1] - wrap_n[0] != A_HT * A_D) begin
            failures++;
            $display("FAIL line_period wraps=%0d exp period=%0d", wrap_n.size(), A_HT * A_D);
        end
    endtask

    task automatic test_clk_div1();
        int pe_low = 0, act_cnt = 0, fs_seen = 0, fs_first = 0, period = 0;
        logic hit_top = 1'b0;
        for (int i = 0; i < 2 * C_HT * C_VT + 16; i++) begin
            @(negedge sysclk);
            checks++;
            if (c_obs !== exp_c(n)) begin
                failures++;
                if (failures < 20) $display("FAIL div1_model n=%0d got=%h exp=%h", n, c_obs, exp_c(n));
            end
            if (!c_pe) pe_low++;
            if (c_fs) begin
                if (fs_seen >= 1) begin
                    checks++;
                    if (act_cnt != C_HAL * C_VAL) begin
                        failures++;
                        $display("FAIL div1_active_count got=%0d exp=%0d", act_cnt, C_HAL * C_VAL);
                    end
                    if (fs_seen == 1) period = n - fs_first;
                end else begin
                    fs_first = n;
                end
                fs_seen++;
                act_cnt = 0;
            end
            if (c_act) act_cnt++;
            if (c_act && c_addr[19:10] == 10'd1023) hit_top = 1'b1;
        end
        checks++;
        if (pe_low != 0) begin
            failures++;
            $display("FAIL div1_pixel_en low_cycles=%0d exp=0", pe_low);
        end
        checks++;
        if (period != C_HT * C_VT) begin
            failures++;
            $display("FAIL div1_frame_period got=%0d exp=%0d", period, C_HT * C_VT);
        end
        checks++;
        if (!hit_top) begin
            failures++;
            $display("FAIL div1_active_h1023 got=0 exp=1");
        end
    endtask

    task automatic test_frames();
        int pulses = 0, act_cnt = 0;
        logic saw_wrap = 1'b0;
        logic [7:0] prev_fc = b_fc;
        for (int i = 0; i < 260 * B_HT * B_VT * B_D && pulses < 257; i++) begin
            @(negedge sysclk);
            checks++;
            if (b_obs !== exp_b(n)) begin
                failures++;
                if (failures < 20) $display("FAIL frames_model n=%0d got=%h exp=%h", n, b_obs, exp_b(n));
            end
            if (b_fs) begin
                if (pulses > 0) begin
                    checks++;
                    if (act_cnt != B_HAL * B_VAL) begin
                        failures++;
                        $display("FAIL frame_active_count got=%0d exp=%0d", act_cnt, B_HAL * B_VAL);
                    end
                end
                pulses++;
                act_cnt = 0;
            end
            if (b_act && b_pe) act_cnt++;
            if (prev_fc == 8'd255 && b_fc == 8'd0) saw_wrap = 1'b1;
            prev_fc = b_fc;
        end
        checks++;
        if (pulses != 257) begin
            failures++;
            $display("FAIL frame_pulses got=%0d exp=257", pulses);
        end
        checks++;
        if (!saw_wrap) begin
            failures++;
            $display("FAIL frame_count_wrap got=0 exp=1");
        end
    endtask

    task automatic test_mid_reset();
        for (int r = 0; r < 3; r++) begin
            logic seen = 1'b0;
            repeat ($urandom_range(200, 1000)) @(negedge sysclk);
            @(posedge sysclk);
            #($urandom_range(1, 8));
            rst_n = 1'b0;
            #1;
            checks++;
            if (a_obs !== 35'h0 || b_obs !== 35'h0 || c_obs !== 35'h0) begin
                failures++;
                $display("FAIL async_clear got a=%h b=%h c=%h exp=0", a_obs, b_obs, c_obs);
            end
            repeat ($urandom_range(1, 5)) @(negedge sysclk);
            rst_n = 1'b1;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge sysclk);
                if (b_pe) seen = 1'b1;
            end
            checks++;
            if (!seen || b_addr[19:10] !== 10'd1 || b_addr[9:0] !== 10'd0 || n != B_D) begin
                failures++;
                $display("FAIL restart_first_pixel seen=%0d n=%0d h=%0d v=%0d exp n=%0d h=1 v=0",
                         seen, n, b_addr[19:10], b_addr[9:0], B_D);
            end
            for (int i = 0; i < 300; i++) begin
                @(negedge sysclk);
                checks++;
                if (a_obs !== exp_a(n) || b_obs !== exp_b(n) || c_obs !== exp_c(n)) begin
                    failures++;
                    if (failures < 20)
                        $display("FAIL restart_model n=%0d got a=%h b=%h c=%h exp a=%h b=%h c=%h",
                                 n, a_obs, b_obs, c_obs, exp_a(n), exp_b(n), exp_c(n));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_line();
        test_clk_div1();
        test_frames();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
